square64: RTL and testbench

- Bit-serial squarer. Computes y = a*a, one multiplier bit per clock, MSB first, using Horner shift-add.
- It is the inverse companion of the team's bit-serial square-root unit. It generates squares for building root test vectors and for checking root results in the same datapath.
- Single clock domain with a start/busy/rdy handshake.

---
 rtl/square64.sv | 107 ++++++++++
 tb/tb_square64.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/square64.sv
// Bit-serial squarer: y = a*a via MSB-first Horner shift-add, one operand bit per clock.
// Optional root check (a == floor(sqrt(x))) is enabled by defining SQUARE64_ROOTCHECK_EN.
module square64 #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
`ifdef SQUARE64_ROOTCHECK_EN
  input  logic [2*WIDTH-1:0]   x,
  output logic                 root_ok,
`endif
  output logic                 busy,
  output logic                 rdy,
  output logic [2*WIDTH-1:0]   y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   opnd_sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      cnt;
  logic               last;
  logic               accept;

  // Handshake: start is accepted only from IDLE or DONE; rdy holds until the next accept.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign last   = (cnt == '0);

  // Shift keeps the bit select independent of the counter width.
  assign opnd_sh  = opnd >> cnt;
  assign acc_step = {acc[2*WIDTH-2:0], 1'b0} +
                    (opnd_sh[0] ? {{WIDTH{1'b0}}, opnd} : {(2*WIDTH){1'b0}});

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    rdy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        rdy = 1'b1;
        if (start) state_nxt = S_BUSY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SQUARE64_ROOTCHECK_EN
  logic [2*WIDTH-1:0] x_r;
  logic [2*WIDTH:0]   upper;
  logic               root_ok_nxt;

  // (a+1)^2 = a^2 + 2a + 1, one bit wider so a = 2^WIDTH-1 cannot wrap.
  assign upper = {1'b0, acc_step} + ({{(WIDTH+1){1'b0}}, opnd} << 1) + (2*WIDTH+1)'(1);
  assign root_ok_nxt = (acc_step <= x_r) && ({1'b0, x_r} < upper);

  always_ff @(posedge clk) begin
    if (reset) begin
      x_r     <= '0;
      root_ok <= 1'b0;
    end else if (accept) begin
      x_r <= x;
    end else if (busy && last) begin
      root_ok <= root_ok_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      opnd  <= '0;
      acc   <= '0;
      cnt   <= '0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opnd <= a;
        acc  <= '0;
        cnt  <= CW'(WIDTH-1);
      end else if (busy) begin
        acc <= acc_step;
        cnt <= cnt - 1'b1;
        if (last) y <= acc_step;
      end
    end
  end

endmodule

// File: tb/tb_square64.sv
// Directed + random bench for square64; build with SQUARE64_ROOTCHECK_EN to cover the root check.
module tb_square64;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic           busy;
  logic           rdy;
  logic [2*W-1:0] y;
`ifdef SQUARE64_ROOTCHECK_EN
  logic [2*W-1:0] x;
  logic           root_ok;
  logic           exp_ok_q[$];
`endif

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_y;
  int total = 0;
  int bad   = 0;

  square64 #(.WIDTH(W), .CW(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
`ifdef SQUARE64_ROOTCHECK_EN
    .x      (x),
    .root_ok(root_ok),
`endif
    .busy   (busy),
    .rdy    (rdy),
    .y      (y)
  );

  always #5 clk = ~clk;

  // Reference model: plain wide arithmetic.
  function automatic logic [2*W-1:0] model_sq(input logic [W-1:0] av);
    logic [2*W-1:0] aa;
    aa = {{W{1'b0}}, av};
    return aa * aa;
  endfunction

  function automatic logic model_root(input logic [W-1:0] av, input logic [2*W-1:0] xv);
    logic [2*W+1:0] aa, lo, hi, xx;
    aa = {{(W+2){1'b0}}, av};
    lo = aa * aa;
    hi = (aa + 1) * (aa + 1);
    xx = {2'b00, xv};
    return (xx >= lo) && (xx < hi);
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [2*W-1:0] xv);
    start = 1'b1;
    a     = av;
`ifdef SQUARE64_ROOTCHECK_EN
    x     = xv;
    exp_ok_q.push_back(model_root(av, xv));
`else
    if (xv != '0) ; // x only exists with the root check
`endif
    exp_q.push_back(model_sq(av));
    tick();
    start = 1'b0;
    a     = $urandom;
`ifdef SQUARE64_ROOTCHECK_EN
    x     = {$urandom, $urandom};
`endif
  endtask

  task automatic wait_done(input string tag, input bit poke);
    int cycles;
    logic [2*W-1:0] e;
    cycles = 0;
    check({tag, "_busy0"}, busy, 1);
    check({tag, "_rdy0"}, rdy, 0);
    check({tag, "_yhold"}, y, last_y);
    while (!rdy && cycles < W + 8) begin
      if (poke && cycles == 5) begin
        start = 1'b1;
        a     = 7;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
      cycles++;
    end
    check({tag, "_latency"}, cycles, W);
    check({tag, "_busy_end"}, busy, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_y"}, y, e);
    last_y = e;
`ifdef SQUARE64_ROOTCHECK_EN
    if (exp_ok_q.size() > 0) check({tag, "_root_ok"}, root_ok, exp_ok_q.pop_front());
`endif
  endtask

  initial begin
    int seen;
    logic [W-1:0]   ra;
    logic [2*W-1:0] sq, rx;

    reset = 1'b1; start = 1'b0; a = '0; last_y = '0;
`ifdef SQUARE64_ROOTCHECK_EN
    x = '0;
`endif
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_rdy", rdy, 0);
    check("rst_y", y, 0);
`ifdef SQUARE64_ROOTCHECK_EN
    check("rst_root_ok", root_ok, 0);
`endif
    reset = 1'b0;
    tick();

    issue(32'd12345, 64'd0);
    wait_done("a12345", 1'b0);
    check("const_12345", y, 64'd152399025);

    issue(32'hFFFF_FFFF, 64'd0);
    wait_done("amax", 1'b0);
    check("const_amax", y, 64'hFFFF_FFFE_0000_0001);

    issue(32'd0, 64'd0);
    wait_done("azero", 1'b0);
    check("const_zero", y, 64'd0);

    issue(32'd3037000499, 64'd0);
    wait_done("poke", 1'b1);
    check("const_3037000499", y, 64'd9223372030926249001);

    // Back-to-back from DONE.
    issue(32'd3, 64'd0);
    wait_done("b2b_3", 1'b0);
    check("const_9", y, 64'd9);
    issue(32'd5, 64'd0);
    wait_done("b2b_5", 1'b0);
    check("const_25", y, 64'd25);

    // Abort with reset at BUSY cycle 10.
    issue(32'd1000, 64'd0);
    for (int i = 0; i < 9; i++) tick();
    check("abort_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rdy", rdy, 0);
    check("abort_y", y, 0);
    exp_q.delete();
`ifdef SQUARE64_ROOTCHECK_EN
    exp_ok_q.delete();
    check("abort_root_ok", root_ok, 0);
`endif
    last_y = '0;
    seen = 0;
    for (int i = 0; i < W + 8; i++) begin
      tick();
      if (rdy) seen++;
    end
    check("abort_no_rdy", seen, 0);
    issue(32'd2, 64'd0);
    wait_done("after_abort", 1'b0);
    check("const_4", y, 64'd4);

`ifdef SQUARE64_ROOTCHECK_EN
    issue(32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done("rc_max", 1'b0);
    check("rc_max_const", root_ok, 1);
    issue(32'd4, 64'd24);
    wait_done("rc_4_24", 1'b0);
    check("rc_4_24_const", root_ok, 1);
    issue(32'd4, 64'd25);
    wait_done("rc_4_25", 1'b0);
    check("rc_4_25_const", root_ok, 0);
    issue(32'd5, 64'd24);
    wait_done("rc_5_24", 1'b0);
    check("rc_5_24_const", root_ok, 0);
`endif

    // Random operands, with x placed around the a^2 .. (a+1)^2 boundaries.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      if (i == 0) ra = 32'd1;
      sq = model_sq(ra);
      case ($urandom_range(0, 3))
        0:       rx = sq;
        1:       rx = sq - 1;
        2:       rx = sq + {{W{1'b0}}, ra} + {{W{1'b0}}, ra};
        default: rx = sq + {{W{1'b0}}, ra} + {{W{1'b0}}, ra} + 1;
      endcase
      issue(ra, rx);
      wait_done($sformatf("rand%0d", i), (i % 4) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
